// File: rtl/sseg_arb_pkg.sv
// rtl/sseg_arb_pkg.sv - shared state encoding and widths for the seven-segment display arbiter
package sseg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_t;

    localparam int HEX_W              = 4;
    localparam int DEFAULT_HOLD_TICKS = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin search for the first set request at or above ptr
module rr_priority_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        wrap_idx = IDX_W'((int'(base) + offset) % N_REQ);
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (!any && req[cand]) begin
                any         = 1'b1;
                winner[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// rtl/sseg_display_arbiter.sv - round-robin owner of the seven-segment display with minimum hold time
// Optional macro SSEG_ARB_LZ_BLANK_EN enables leading-zero digit blanking.
module sseg_display_arbiter
    import sseg_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int N_SSEGS    = 4,
    parameter  int HOLD_TICKS = DEFAULT_HOLD_TICKS,
    localparam int OWN_W      = $clog2(N_REQ),
    localparam int DATA_W     = HEX_W * N_SSEGS
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_ce,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]          o_grant,
    output logic [OWN_W-1:0]          o_owner,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_hex_data,
    output logic [N_SSEGS-1:0]        o_digit_blank
);

    localparam logic [7:0]       HOLD_MAX = 8'(HOLD_TICKS);
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]          hold_q, hold_d;
    logic [N_REQ-1:0]    grant_d;
    logic [OWN_W-1:0]    owner_d;
    logic                valid_d;
    logic [DATA_W-1:0]   hex_d;
    logic [N_SSEGS-1:0]  blank_d;

    logic [N_REQ-1:0]    pick_onehot;
    logic [OWN_W-1:0]    pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   owner_slice;
    logic                owner_req;
    logic                others_req;

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (i_req),
        .ptr    (rr_ptr_q),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        owner_slice = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_owner == OWN_W'(k)) begin
                owner_slice = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_req  = i_req[o_owner];
    assign others_req = |(i_req & ~o_grant);

`ifdef SSEG_ARB_LZ_BLANK_EN
    // Digit 0 always shows, so an all-zero value still displays a single "0".
    function automatic logic [N_SSEGS-1:0] lz_mask(input logic [DATA_W-1:0] hex);
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int d = N_SSEGS - 1; d > 0; d--) begin
            if (hex[d*HEX_W +: HEX_W] != '0) begin
                seen = 1'b1;
            end
            lz_mask[d] = ~seen;
        end
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        grant_d  = o_grant;
        owner_d  = o_owner;
        valid_d  = o_valid;
        hex_d    = o_hex_data;

        case (state_q)
            ST_OWN: begin
                hex_d = owner_slice;
                if (i_ce && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 8'd1;
                end
                if (!owner_req || ((hold_q == HOLD_MAX) && others_req)) begin
                    state_d  = ST_SWITCH;
                    grant_d  = '0;
                    rr_ptr_d = (o_owner == LAST_IDX) ? '0 : o_owner + OWN_W'(1);
                end
            end
            ST_IDLE, ST_SWITCH: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

`ifdef SSEG_ARB_LZ_BLANK_EN
        blank_d = valid_d ? lz_mask(hex_d) : '1;
`else
        blank_d = {N_SSEGS{~valid_d}};
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            hold_q        <= '0;
            o_grant       <= '0;
            o_owner       <= '0;
            o_valid       <= 1'b0;
            o_hex_data    <= '0;
            o_digit_blank <= '1;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_q        <= hold_d;
            o_grant       <= grant_d;
            o_owner       <= owner_d;
            o_valid       <= valid_d;
            o_hex_data    <= hex_d;
            o_digit_blank <= blank_d;
        end
    end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// tb/tb_sseg_display_arbiter.sv - scoreboard bench for sseg_display_arbiter against a behavioural model
module tb_sseg_display_arbiter;

    localparam int N_REQ = 4;
    localparam int HOLD  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        valid;
    logic [15:0] hex;
    logic [3:0]  blank;

    always #5 clk = ~clk;

    sseg_display_arbiter #(.N_REQ(N_REQ), .N_SSEGS(4), .HOLD_TICKS(HOLD)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_ce          (ce),
        .i_req         (req),
        .i_data        (data),
        .o_grant       (grant),
        .o_owner       (owner),
        .o_valid       (valid),
        .o_hex_data    (hex),
        .o_digit_blank (blank)
    );

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] hex;
        logic [3:0]  blank;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: who holds the display (-1 = nobody), where the next search starts, strobes seen.
    int          holder  = -1;
    int          ptr     = 0;
    int          strobes = 0;
    int          last    = 0;
    bit          showing = 0;
    logic [15:0] shown   = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        obs_t e;
        int   w;
        bit   others;
        if (!rst_n) begin
            holder = -1; ptr = 0; strobes = 0; last = 0; showing = 0; shown = '0;
        end else if (holder >= 0) begin
            shown  = data[holder*16 +: 16];
            others = (req & ~(4'b0001 << holder)) != 4'b0;
            if (!req[holder] || (strobes == HOLD && others)) begin
                ptr    = (holder + 1) % N_REQ;
                holder = -1;
            end else if (ce && strobes < HOLD) begin
                strobes++;
            end
        end else begin
            w = -1;
            for (int i = 0; i < N_REQ; i++)
                if (w < 0 && req[(ptr + i) % N_REQ]) w = (ptr + i) % N_REQ;
            if (w >= 0) begin
                holder = w; last = w; strobes = 0; showing = 1;
            end else begin
                showing = 0;
            end
        end
        e.grant = (holder >= 0) ? (4'b0001 << holder) : 4'b0000;
        e.owner = 2'(last);
        e.valid = showing;
        e.hex   = shown;
        for (int d = 0; d < 4; d++) begin
`ifdef SSEG_ARB_LZ_BLANK_EN
            e.blank[d] = !showing || (d > 0 && 32'(shown) < (32'h1 << (4 * d)));
`else
            e.blank[d] = !showing;
`endif
        end
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic [63:0] d, input logic c);
        rst_n = r; req = rq; data = d; ce = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_data();
        logic [63:0] d;
        d = {$urandom, $urandom};
        for (int s = 0; s < 4; s++)
            d[s*16 +: 16] = d[s*16 +: 16] >> (4 * $urandom_range(0, 4));
        return d;
    endfunction

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: got 0 entries want >=1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("grant", 64'(grant), 64'(e.grant));
                chk("owner", 64'(owner), 64'(e.owner));
                chk("valid", 64'(valid), 64'(e.valid));
                chk("hex",   64'(hex),   64'(e.hex));
                chk("blank", 64'(blank), 64'(e.blank));
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [3:0]  r;
        logic        rs;
        d = 64'h1111_3A6D_2222_0007;

        drive(1'b0, 4'b0000, d, 1'b0);
        drive(1'b0, 4'b0000, d, 1'b0);
        chk("reset_grant", 64'(grant), 64'h0);
        chk("reset_blank", 64'(blank), 64'hF);

        drive(1'b1, 4'b0100, d, 1'b0);
        chk("first_grant", 64'(grant), 64'h4);
        drive(1'b1, 4'b0100, d, 1'b0);
        chk("first_hex",   64'(hex),   64'h3A6D);
        chk("first_owner", 64'(owner), 64'h2);
        chk("first_valid", 64'(valid), 64'h1);
        drive(1'b1, 4'b0000, d, 1'b0);
        drive(1'b1, 4'b0000, d, 1'b0);
        chk("idle_valid", 64'(valid), 64'h0);
        chk("idle_hex",   64'(hex),   64'h3A6D);

        for (int i = 0; i < 30; i++) drive(1'b1, 4'b0011, d, i[0]);
        for (int i = 0; i < 80; i++) drive(1'b1, 4'b1111, rand_data(), 1'b1);
        for (int i = 0; i < 6; i++)  drive(1'b1, 4'b1010, d, 1'b1);
        for (int i = 0; i < 4; i++)  drive(1'b1, 4'b1000, d, 1'b1);

        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, d, 1'b1);
        drive(1'b0, 4'b0001, d, 1'b1);
        chk("midown_reset_grant", 64'(grant), 64'h0);
        chk("midown_reset_valid", 64'(valid), 64'h0);
        chk("midown_reset_hex",   64'(hex),   64'h0);
        drive(1'b1, 4'b0001, d, 1'b0);
        chk("post_reset_grant", 64'(grant), 64'h1);

        r = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
            rs = ($urandom_range(0, 499) != 0);
            drive(rs, r, rand_data(), ($urandom_range(0, 2) == 0));
        end

        #5;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
